// File: rtl/audio_pkg.sv
// Shared sample/volume widths, the sample type and the default-width gain constants
// for the volume_adjust pipeline (optional feature macro: VOLUME_RAMP_EN).
package audio_pkg;

  localparam int DEF_SAMPLE_BITS = 16;
  localparam int DEF_VOLUME_BITS = 8;

  typedef logic signed [DEF_SAMPLE_BITS-1:0] sample_t;

  // Volume code that gives a gain of exactly 1.0, and the half-LSB rounding bias.
  localparam int UNITY_GAIN  = 1 << (DEF_VOLUME_BITS - 1);
  localparam int ROUND_CONST = 1 << (DEF_VOLUME_BITS - 2);

endpackage

// File: rtl/volume_ramp.sv
// Effective-volume slew register: steps one LSB toward the target per accepted sample.
// Only built when VOLUME_RAMP_EN is defined.
`ifdef VOLUME_RAMP_EN
module volume_ramp
  import audio_pkg::*;
#(
  parameter int VOLUME_BITS = DEF_VOLUME_BITS
) (
  input  logic                   mclk,
  input  logic                   rst,
  input  logic                   step_en,
  input  logic [VOLUME_BITS-1:0] target,
  output logic [VOLUME_BITS-1:0] eff_vol
);

  logic [VOLUME_BITS-1:0] eff_q, eff_d;

  always_comb begin
    eff_d = eff_q;
    if (step_en) begin
      if (eff_q < target) begin
        eff_d = eff_q + VOLUME_BITS'(1);
      end else if (eff_q > target) begin
        eff_d = eff_q - VOLUME_BITS'(1);
      end
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      eff_q <= '0;
    end else begin
      eff_q <= eff_d;
    end
  end

  assign eff_vol = eff_q;

endmodule
`endif

// File: rtl/volume_adjust.sv
// Two-stage signed PCM volume scaler: multiply, then round-half-up, shift and saturate.
// Define VOLUME_RAMP_EN to slew the effective volume through volume_ramp.
module volume_adjust
  import audio_pkg::*;
#(
  parameter int SAMPLE_BITS = DEF_SAMPLE_BITS,
  parameter int VOLUME_BITS = DEF_VOLUME_BITS
) (
  input  logic                          mclk,
  input  logic                          rst,
  input  logic signed [SAMPLE_BITS-1:0] sample_in,
  input  logic                          in_valid,
  input  logic        [VOLUME_BITS-1:0] volume,
  output logic signed [SAMPLE_BITS-1:0] sample_out,
  output logic                          out_valid,
  output logic                          clipped
);

  localparam int PW    = SAMPLE_BITS + VOLUME_BITS + 1;
  localparam int SHIFT = VOLUME_BITS - 1;
  localparam int RW    = PW - SHIFT;

  localparam logic        [PW-1:0] RND  = {{(PW-1){1'b0}}, 1'b1} << (VOLUME_BITS - 2);
  localparam logic signed [RW-1:0] SMAX = $signed(RW'({1'b0, {(SAMPLE_BITS-1){1'b1}}}));
  localparam logic signed [RW-1:0] SMIN = ~SMAX;

  function automatic logic signed [RW-1:0] round_shift(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] biased;
    biased = p + $signed(RND);
    return RW'(biased >>> SHIFT);
  endfunction

  // Returns {clip_flag, saturated_sample}.
  function automatic logic [SAMPLE_BITS:0] saturate(input logic signed [RW-1:0] r);
    logic [SAMPLE_BITS:0] res;
    if (r > SMAX) begin
      res = {1'b1, SMAX[SAMPLE_BITS-1:0]};
    end else if (r < SMIN) begin
      res = {1'b1, SMIN[SAMPLE_BITS-1:0]};
    end else begin
      res = {1'b0, r[SAMPLE_BITS-1:0]};
    end
    return res;
  endfunction

  logic [VOLUME_BITS-1:0] eff_vol;

`ifdef VOLUME_RAMP_EN
  volume_ramp #(
    .VOLUME_BITS(VOLUME_BITS)
  ) u_ramp (
    .mclk    (mclk),
    .rst     (rst),
    .step_en (in_valid),
    .target  (volume),
    .eff_vol (eff_vol)
  );
`else
  assign eff_vol = volume;
`endif

  // Stage 1: full-precision product, gain captured at acceptance
  logic signed [PW-1:0] prod_d, prod_p1_q;
  logic                 vld_p1_q;

  assign prod_d = PW'(sample_in) * $signed(PW'(eff_vol));

  always_ff @(posedge mclk) begin
    if (in_valid) begin
      prod_p1_q <= prod_d;
    end
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else begin
      vld_p1_q <= in_valid;
    end
  end

  // Stage 2: round, shift, saturate; outputs hold between strobes
  logic [SAMPLE_BITS:0]          res_d;
  logic signed [SAMPLE_BITS-1:0] sample_p2_q;
  logic                          clip_p2_q;
  logic                          vld_p2_q;

  assign res_d = saturate(round_shift(prod_p1_q));

  always_ff @(posedge mclk) begin
    if (rst) begin
      vld_p2_q    <= 1'b0;
      sample_p2_q <= '0;
      clip_p2_q   <= 1'b0;
    end else begin
      vld_p2_q <= vld_p1_q;
      if (vld_p1_q) begin
        sample_p2_q <= $signed(res_d[SAMPLE_BITS-1:0]);
        clip_p2_q   <= res_d[SAMPLE_BITS];
      end
    end
  end

  assign sample_out = sample_p2_q;
  assign clipped    = clip_p2_q;
  assign out_valid  = vld_p2_q;

endmodule

// File: tb/tb_volume_adjust.sv
// Scoreboard bench for volume_adjust (16-bit samples, 8-bit volume); honours VOLUME_RAMP_EN.
module tb_volume_adjust;
  import audio_pkg::*;

  logic    mclk = 1'b0;
  logic    rst;
  sample_t sample_in;
  logic    in_valid;
  logic [7:0] volume;
  sample_t sample_out;
  logic    out_valid;
  logic    clipped;

  volume_adjust #(.SAMPLE_BITS(16), .VOLUME_BITS(8)) dut (
    .mclk       (mclk),
    .rst        (rst),
    .sample_in  (sample_in),
    .in_valid   (in_valid),
    .volume     (volume),
    .sample_out (sample_out),
    .out_valid  (out_valid),
    .clipped    (clipped)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int eff_m = 0;

  always @(posedge mclk) cyc <= cyc + 1;

  typedef struct {
    int val;
    bit clip;
    int due;
  } exp_t;

  exp_t exp_q[$];

  // Scoreboard: every strobe must match the oldest expectation, on its due cycle.
  always @(negedge mclk) begin
    if (out_valid) begin
      if (exp_q.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL unexpected_out_valid cyc=%0d sample_out=%0d", cyc, sample_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        if (int'(sample_out) !== e.val || clipped !== e.clip || cyc != e.due) begin
          errors++;
          $display("FAIL scoreboard got val=%0d clip=%0b cyc=%0d expected val=%0d clip=%0b cyc=%0d",
                   sample_out, clipped, cyc, e.val, e.clip, e.due);
        end
      end
    end
  end

  function automatic int model(input int s, input int v, output bit c);
    longint p, r;
    p = longint'(s) * longint'(v);
    r = (p + 64) >>> 7;
    c = 1'b0;
    if (r > 32767) begin
      r = 32767; c = 1'b1;
    end else if (r < -32768) begin
      r = -32768; c = 1'b1;
    end
    return int'(r);
  endfunction

  task automatic drive(input int s, input int v, input int ev, input bit ec);
    exp_t e;
    @(posedge mclk); #1;
    sample_in = sample_t'(s);
    volume    = 8'(v);
    in_valid  = 1'b1;
    e.val = ev; e.clip = ec; e.due = cyc + 2;
    exp_q.push_back(e);
  endtask

  task automatic drive_model(input int s, input int v);
    int eff, ev;
    bit ec;
`ifdef VOLUME_RAMP_EN
    eff = eff_m;
    if (eff_m < v) eff_m++;
    else if (eff_m > v) eff_m--;
`else
    eff = v;
`endif
    ev = model(s, eff, ec);
    drive(s, v, ev, ec);
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(posedge mclk); #1;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 10) begin
      @(negedge mclk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain pending=%0d expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; sample_in = '0; volume = '0;
    repeat (3) @(posedge mclk);
    @(negedge mclk);
    checks++;
    if (out_valid !== 1'b0 || sample_out !== 16'sd0 || clipped !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got v=%0b s=%0d c=%0b expected 0 0 0", out_valid, sample_out, clipped);
    end
    @(posedge mclk); #1;
    rst = 1'b0;
    eff_m = 0;
  endtask

`ifndef VOLUME_RAMP_EN
  task automatic test_unity();
    drive(1000, UNITY_GAIN, 1000, 1'b0);
    drive(-1, UNITY_GAIN, -1, 1'b0);
    drive(-32768, UNITY_GAIN, -32768, 1'b0);
    drain("unity");
  endtask

  task automatic test_rounding();
    drive(1000, 64, 500, 1'b0);
    drive(-1, 64, 0, 1'b0);
    drive(3, 64, 2, 1'b0);
    drive(12345, 0, 0, 1'b0);
    drain("rounding");
  endtask

  task automatic test_clip();
    drive(20000, 255, 32767, 1'b1);
    drive(-32768, 255, -32768, 1'b1);
    drive(100, 255, 199, 1'b0);
    drain("clip");
  endtask
`endif

  task automatic test_back_to_back();
    sample_t hv;
    logic hc;
    for (int i = 0; i < 9; i++) begin
      drive_model(int'($urandom_range(65535)) - 32768, (i * 29 + 7) % 256);
    end
    drive_model(30000, 255);
    drain("back_to_back");
    hv = sample_out;
    hc = clipped;
    for (int i = 0; i < 3; i++) begin
      @(posedge mclk); #1;
      sample_in = sample_t'(i * 777 - 5000);
      volume    = 8'(i * 50);
      @(negedge mclk);
      checks++;
      if (out_valid !== 1'b0 || sample_out !== hv || clipped !== hc) begin
        errors++;
        $display("FAIL hold_%0d got v=%0b s=%0d c=%0b expected 0 %0d %0b",
                 i, out_valid, sample_out, clipped, hv, hc);
      end
    end
  endtask

  task automatic test_reset_flush();
    @(posedge mclk); #1;
    sample_in = 16'sd1234; volume = 8'd128; in_valid = 1'b1;
    @(posedge mclk); #1;
    sample_in = -16'sd4321; rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0; in_valid = 1'b0;
    eff_m = 0;
    @(negedge mclk);
    checks++;
    if (out_valid !== 1'b0 || sample_out !== 16'sd0 || clipped !== 1'b0) begin
      errors++;
      $display("FAIL reset_flush got v=%0b s=%0d c=%0b expected 0 0 0", out_valid, sample_out, clipped);
    end
    repeat (4) @(negedge mclk);
    checks++;
    if (sample_out !== 16'sd0) begin
      errors++;
      $display("FAIL reset_flush_quiet got s=%0d expected 0", sample_out);
    end
  endtask

`ifdef VOLUME_RAMP_EN
  task automatic test_ramp();
    rst = 1'b1;
    @(posedge mclk); #1;
    rst = 1'b0;
    drive(1000, 3, 0, 1'b0);
    drive(1000, 3, 8, 1'b0);
    drive(1000, 3, 16, 1'b0);
    drive(1000, 3, 23, 1'b0);
    drive(1000, 3, 23, 1'b0);
    drain("ramp");
    eff_m = 3;
  endtask
`endif

  initial begin
    test_reset();
`ifndef VOLUME_RAMP_EN
    test_unity();
    test_rounding();
    test_clip();
`endif
    test_back_to_back();
    test_reset_flush();
`ifdef VOLUME_RAMP_EN
    test_ramp();
`endif
    repeat (2) @(posedge mclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cyc=%0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
